// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter for the integer register file.
// After reset it optionally zero-fills x1..x31 before servicing writebacks.
module regfile_write_arbiter #(
   parameter int XLEN    = 64,
   parameter bit INIT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0,
   input  logic [4:0]      rd0,
   input  logic [XLEN-1:0] data0,
   output logic            gnt0,
   input  logic            req1,
   input  logic [4:0]      rd1,
   input  logic [XLEN-1:0] data1,
   output logic            gnt1,
   output logic            RegWrite,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] WriteData,
   output logic            busy,
   output logic            conflict
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r;
   logic [4:0]      cnt_r;
   logic            last_r;

   logic            gnt0_s;
   logic            gnt1_s;
   logic            we_s;
   logic [4:0]      rd_s;
   logic [XLEN-1:0] wd_s;
   logic            busy_s;
   logic            conf_s;

   // Grant decode and write-port mux; zero latency so the grant and the write share a cycle.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      we_s   = 1'b0;
      rd_s   = 5'd0;
      wd_s   = {XLEN{1'b0}};
      busy_s = 1'b0;
      conf_s = 1'b0;
      if (reset) begin
         busy_s = 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               we_s   = 1'b1;
               rd_s   = cnt_r;
               busy_s = 1'b1;
            end
            ST_RUN: begin
               // On a tie, last_r == 1 means requester 1 won last time, so requester 0 goes now.
               if (req0 && req1) begin
                  conf_s = 1'b1;
                  if (last_r) begin
                     gnt0_s = 1'b1;
                  end else begin
                     gnt1_s = 1'b1;
                  end
               end else if (req0) begin
                  gnt0_s = 1'b1;
               end else if (req1) begin
                  gnt1_s = 1'b1;
               end else begin
                  conf_s = 1'b0;
               end

               if (gnt0_s) begin
                  rd_s = rd0;
                  wd_s = data0;
                  we_s = (rd0 != 5'd0);
               end else if (gnt1_s) begin
                  rd_s = rd1;
                  wd_s = data1;
                  we_s = (rd1 != 5'd0);
               end else begin
                  we_s = 1'b0;
               end
            end
            default: begin
               we_s = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state, fill counter and last-grant pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= INIT_EN ? ST_INIT : ST_RUN;
         cnt_r   <= 5'd1;
         last_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_INIT: begin
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd31) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_INIT;
               end
            end
            ST_RUN: begin
               if (gnt0_s) begin
                  last_r <= 1'b0;
               end else if (gnt1_s) begin
                  last_r <= 1'b1;
               end else begin
                  last_r <= last_r;
               end
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_s;
   assign gnt1      = gnt1_s;
   assign RegWrite  = we_s;
   assign rd        = rd_s;
   assign WriteData = wd_s;
   assign busy      = busy_s;
   assign conflict  = conf_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: each stimulus cycle queues its expected outputs; a negedge monitor compares.
module tb_regfile_write_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req0, req1, gnt0, gnt1, RegWrite, busy, conflict;
   logic [4:0]  rd0, rd1, rd;
   logic [63:0] data0, data1, WriteData;

   logic        b_req0, b_req1, b_gnt0, b_gnt1, b_we, b_busy, b_conf;
   logic [4:0]  b_rd0, b_rd1, b_rd;
   logic [63:0] b_data0, b_data1, b_wd;

   regfile_write_arbiter #(.XLEN(64), .INIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .rd0(rd0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .rd1(rd1), .data1(data1), .gnt1(gnt1),
      .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
      .busy(busy), .conflict(conflict)
   );

   regfile_write_arbiter #(.XLEN(64), .INIT_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset),
      .req0(b_req0), .rd0(b_rd0), .data0(b_data0), .gnt0(b_gnt0),
      .req1(b_req1), .rd1(b_rd1), .data1(b_data1), .gnt1(b_gnt1),
      .RegWrite(b_we), .rd(b_rd), .WriteData(b_wd),
      .busy(b_busy), .conflict(b_conf)
   );

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic        g0;
      logic        g1;
      logic        busy;
      logic        conf;
      logic        b_we;
      logic [4:0]  b_rd;
      logic [63:0] b_wd;
      logic        b_g0;
      logic        b_g1;
      logic        b_busy;
   } exp_t;

   exp_t  expq[$];
   string tagq[$];
   int    total = 0;
   int    bad   = 0;

   function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [63:0] d,
                               input logic g0, input logic g1, input logic bz, input logic cf);
      exp_t e;
      e      = '0;
      e.we   = we;
      e.rd   = a;
      e.wd   = d;
      e.g0   = g0;
      e.g1   = g1;
      e.busy = bz;
      e.conf = cf;
      return e;
   endfunction

   task automatic stepb(input string tag, input logic rst,
                        input logic q0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic q1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic bq0, input logic [4:0] ba0, input logic [63:0] bd0,
                        input exp_t e);
      @(posedge clk);
      #1;
      reset   = rst;
      req0    = q0;  rd0   = a0;  data0   = d0;
      req1    = q1;  rd1   = a1;  data1   = d1;
      b_req0  = bq0; b_rd0 = ba0; b_data0 = bd0;
      expq.push_back(e);
      tagq.push_back(tag);
   endtask

   task automatic step(input string tag, input logic rst,
                       input logic q0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic q1, input logic [4:0] a1, input logic [63:0] d1,
                       input exp_t e);
      stepb(tag, rst, q0, a0, d0, q1, a1, d1, 1'b0, 5'd0, 64'd0, e);
   endtask

   exp_t  m_e;
   exp_t  m_a;
   string m_t;

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         m_e = expq.pop_front();
         m_t = tagq.pop_front();
         m_a = {RegWrite, rd, WriteData, gnt0, gnt1, busy, conflict,
                b_we, b_rd, b_wd, b_gnt0, b_gnt1, b_busy};
         total++;
         if (m_a !== m_e) begin
            bad++;
            $display("FAIL %s: got we=%b rd=%0d wd=%h g0=%b g1=%b busy=%b conf=%b b[we=%b rd=%0d wd=%h g0=%b g1=%b busy=%b] want we=%b rd=%0d wd=%h g0=%b g1=%b busy=%b conf=%b b[we=%b rd=%0d wd=%h g0=%b g1=%b busy=%b]",
                     m_t, m_a.we, m_a.rd, m_a.wd, m_a.g0, m_a.g1, m_a.busy, m_a.conf,
                     m_a.b_we, m_a.b_rd, m_a.b_wd, m_a.b_g0, m_a.b_g1, m_a.b_busy,
                     m_e.we, m_e.rd, m_e.wd, m_e.g0, m_e.g1, m_e.busy, m_e.conf,
                     m_e.b_we, m_e.b_rd, m_e.b_wd, m_e.b_g0, m_e.b_g1, m_e.b_busy);
         end
      end
   end

   exp_t z;
   exp_t e;

   initial begin
      reset  = 1'b1;
      req0   = 1'b0; rd0   = 5'd0; data0   = 64'd0;
      req1   = 1'b0; rd1   = 5'd0; data1   = 64'd0;
      b_req0 = 1'b0; b_rd0 = 5'd0; b_data0 = 64'd0;
      b_req1 = 1'b0; b_rd1 = 5'd0; b_data1 = 64'd0;
      z = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Outputs are quiet during reset even with requests present.
      step("rst_idle", 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, z);
      step("rst_req_masked", 1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, z);

      // Zero-fill x1..x31 while requester 0 waits; the INIT_EN=0 copy grants immediately.
      for (int i = 1; i <= 31; i++) begin
         e = mk(1'b1, i[4:0], 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (i == 1) begin
            e.b_we = 1'b1; e.b_rd = 5'd7; e.b_wd = 64'h77; e.b_g0 = 1'b1;
            stepb("init_fill_b_first", 1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0,
                  1'b1, 5'd7, 64'h77, e);
         end else begin
            step("init_fill", 1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, e);
         end
      end
      step("init_exit_grant", 1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0,
           mk(1'b1, 5'd9, 64'h99, 1'b1, 1'b0, 1'b0, 1'b0));
      step("alone0_a5", 1'b0, 1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, 64'd0,
           mk(1'b1, 5'd5, 64'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
      step("idle", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, z);
      step("rd0_consumed", 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55,
           mk(1'b0, 5'd0, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0));
      step("tie_after_rd0", 1'b0, 1'b1, 5'd2, 64'h22, 1'b1, 5'd3, 64'h33,
           mk(1'b1, 5'd2, 64'h22, 1'b1, 1'b0, 1'b0, 1'b1));
      step("tie_held", 1'b0, 1'b1, 5'd2, 64'h22, 1'b1, 5'd3, 64'h33,
           mk(1'b1, 5'd3, 64'h33, 1'b0, 1'b1, 1'b0, 1'b1));
      step("alone0_r4", 1'b0, 1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0,
           mk(1'b1, 5'd4, 64'h44, 1'b1, 1'b0, 1'b0, 1'b0));
      step("alone1_r17", 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd17, 64'hDEAD_BEEF_0000_0011,
           mk(1'b1, 5'd17, 64'hDEAD_BEEF_0000_0011, 1'b0, 1'b1, 1'b0, 1'b0));

      // Reset at counter 10 restarts the fill at x1.
      step("rst_pulse", 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, z);
      for (int i = 1; i <= 10; i++) begin
         step("init_pre", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0,
              mk(1'b1, i[4:0], 64'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      step("rst_mid_init", 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, z);
      for (int i = 1; i <= 31; i++) begin
         step("init_restart", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0,
              mk(1'b1, i[4:0], 64'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      end

      // First tie after reset goes to requester 0, then strict alternation.
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin
            step("rr_tie_g0", 1'b0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77,
                 mk(1'b1, 5'd6, 64'h66, 1'b1, 1'b0, 1'b0, 1'b1));
         end else begin
            step("rr_tie_g1", 1'b0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77,
                 mk(1'b1, 5'd7, 64'h77, 1'b0, 1'b1, 1'b0, 1'b1));
         end
      end
      step("rst_tie_abandon", 1'b1, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77, z);
      step("init_ignores_tie", 1'b0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77,
           mk(1'b1, 5'd1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0));

      @(negedge clk);
      #1;
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending records, want 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
